// File: rtl/cpu_core_p.sv
// Parametrised multi-cycle accumulator CPU core with carry, stack (PUSH/POP/CALL/RET), run-enable and sticky HALT.
// Optional macro CPU_STACK_GUARD_EN: stack overflow/underflow enters a sticky FAULT state instead of wrapping.
module cpu_core_p #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int NREG   = 8,
    parameter int SP_W   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [SP_W-1:0]   smem_addr,
    output logic              smem_we,
    output logic [DATA_W-1:0] smem_wdata,
    input  logic [DATA_W-1:0] smem_rdata,
    output logic              halted,
    output logic              fault,
    output logic [ADDR_W-1:0] o_pc,
    output logic [SP_W-1:0]   o_sp,
    output logic [DATA_W-1:0] o_r0,
    output logic [2:0]        o_state,
    output logic [2:0]        o_flags
);

    localparam int SH_W = $clog2(DATA_W);
    localparam int WIDE = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam logic [7:0] REG_MASK = 8'((1 << NREG) - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,  OP_LD   = 5'd1,  OP_LI   = 5'd2,  OP_MOV  = 5'd3,
        OP_ST   = 5'd4,  OP_SHL  = 5'd5,  OP_ADD  = 5'd6,  OP_SUB  = 5'd7,
        OP_JZ   = 5'd8,  OP_JN   = 5'd9,  OP_JMP  = 5'd10, OP_XOR  = 5'd11,
        OP_OR   = 5'd12, OP_AND  = 5'd13, OP_SHR  = 5'd14, OP_NOT  = 5'd15,
        OP_PUSH = 5'd16, OP_POP  = 5'd17, OP_CALL = 5'd18, OP_RET  = 5'd19,
        OP_JC   = 5'd20, OP_HALT = 5'd31
    } opcode_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc, pc_d, pc_inc, s_pc;
    logic [SP_W-1:0]   sp, sp_d;
    logic              c_flag, c_d;
    logic [15:0]       ir;
    logic              ir_load;

    logic [DATA_W-1:0] rf [8];
    logic              rf_we;
    logic [2:0]        rf_idx;
    logic [DATA_W-1:0] rf_wdata;

    logic [4:0]        op;
    logic [2:0]        fld;
    logic [7:0]        imm;
    logic [DATA_W-1:0] r0, rf_f, imm_ext, s_val;
    logic [DATA_W:0]   sum, diff;
    logic [WIDE-1:0]   s_wide, pc1_wide, stk_wide;
    logic              flag_z, flag_n, guard_trip, stack_pop;

    assign op       = ir[15:11];
    assign fld      = ir[10:8];
    assign imm      = ir[7:0];
    assign r0       = rf[0];
    assign rf_f     = rf[fld];
    assign imm_ext  = DATA_W'(imm);
    assign s_val    = (fld == 3'd0) ? imm_ext : rf_f;
    assign sum      = {1'b0, r0} + {1'b0, s_val};
    assign diff     = {1'b0, r0} - {1'b0, s_val};
    assign flag_z   = (r0 == '0);
    assign flag_n   = r0[DATA_W-1];
    assign pc_inc   = pc + ADDR_W'(1);

    // Width adaptation between DATA_W and ADDR_W goes through a common wide form.
    assign s_wide   = WIDE'(s_val);
    assign pc1_wide = WIDE'(pc_inc);
    assign stk_wide = WIDE'(smem_rdata);
    assign s_pc     = s_wide[ADDR_W-1:0];

    assign stack_pop = (op == OP_POP) || (op == OP_RET);

`ifdef CPU_STACK_GUARD_EN
    assign guard_trip = (((op == OP_PUSH) || (op == OP_CALL)) && (sp == '1)) ||
                        (stack_pop && (sp == '0));
    assign fault      = (state == S_FAULT);
`else
    assign guard_trip = 1'b0;
    assign fault      = 1'b0;
`endif

    assign imem_addr  = pc;
    assign dmem_addr  = ADDR_W'(imm);
    assign dmem_wdata = rf_f;
    assign smem_addr  = stack_pop ? (sp - SP_W'(1)) : sp;
    assign smem_wdata = (op == OP_CALL) ? pc1_wide[DATA_W-1:0] : rf_f;

    assign halted  = (state == S_HALT);
    assign o_pc    = pc;
    assign o_sp    = sp;
    assign o_r0    = r0;
    assign o_state = state;
    assign o_flags = {c_flag, flag_n, flag_z};

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state;
        pc_d     = pc;
        sp_d     = sp;
        c_d      = c_flag;
        ir_load  = 1'b0;
        rf_we    = 1'b0;
        rf_idx   = fld;
        rf_wdata = rf_f;
        dmem_we  = 1'b0;
        smem_we  = 1'b0;

        unique case (state)
            S_FETCH: if (run) state_d = S_DECODE;
            S_DECODE: begin
                ir_load = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                if (guard_trip) begin
                    state_d = S_FAULT;
                    pc_d    = pc;
                end else begin
                    case (op)
                        OP_LD:   state_d = S_MEM;
                        OP_LI:   begin rf_we = 1'b1; rf_wdata = imm_ext; end
                        OP_MOV:  begin rf_we = 1'b1; rf_wdata = rf[ir[2:0]]; end
                        OP_ST:   dmem_we = 1'b1;
                        OP_SHL:  begin rf_we = 1'b1; rf_idx = 3'd0; rf_wdata = r0 << s_val[SH_W-1:0]; end
                        OP_SHR:  begin rf_we = 1'b1; rf_idx = 3'd0; rf_wdata = r0 >> s_val[SH_W-1:0]; end
                        OP_ADD:  begin rf_we = 1'b1; rf_idx = 3'd0; rf_wdata = sum[DATA_W-1:0];  c_d = sum[DATA_W];  end
                        OP_SUB:  begin rf_we = 1'b1; rf_idx = 3'd0; rf_wdata = diff[DATA_W-1:0]; c_d = diff[DATA_W]; end
                        OP_XOR:  begin rf_we = 1'b1; rf_idx = 3'd0; rf_wdata = r0 ^ s_val; end
                        OP_OR:   begin rf_we = 1'b1; rf_idx = 3'd0; rf_wdata = r0 | s_val; end
                        OP_AND:  begin rf_we = 1'b1; rf_idx = 3'd0; rf_wdata = r0 & s_val; end
                        OP_NOT:  begin rf_we = 1'b1; rf_idx = 3'd0; rf_wdata = ~r0; end
                        OP_JZ:   if (flag_z) pc_d = s_pc;
                        OP_JN:   if (flag_n) pc_d = s_pc;
                        OP_JC:   if (c_flag) pc_d = s_pc;
                        OP_JMP:  pc_d = s_pc;
                        OP_PUSH: begin smem_we = 1'b1; sp_d = sp + SP_W'(1); end
                        OP_POP:  begin sp_d = sp - SP_W'(1); state_d = S_MEM; end
                        OP_CALL: begin smem_we = 1'b1; sp_d = sp + SP_W'(1); pc_d = s_pc; end
                        OP_RET:  begin sp_d = sp - SP_W'(1); pc_d = pc; state_d = S_MEM; end
                        OP_HALT: state_d = S_HALT;
                        default: ;
                    endcase
                end
            end
            S_MEM: begin
                state_d = S_FETCH;
                if (op == OP_RET) begin
                    pc_d = stk_wide[ADDR_W-1:0];
                end else begin
                    rf_we    = 1'b1;
                    rf_wdata = (op == OP_POP) ? smem_rdata : dmem_rdata;
                end
            end
            S_HALT, S_FAULT: ;
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_FETCH;
            pc     <= '0;
            sp     <= '0;
            c_flag <= 1'b0;
            ir     <= '0;
        end else begin
            state  <= state_d;
            pc     <= pc_d;
            sp     <= sp_d;
            c_flag <= c_d;
            if (ir_load) ir <= imem_rdata;
        end
    end

    // NOTE: the register file is architectural state and is reset, unlike the external memories.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (rf_we && REG_MASK[rf_idx]) begin
            rf[rf_idx] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_cpu_core_p.sv
// Directed self-checking bench for cpu_core_p with synchronous-read memory models (SP_W=2 to reach the stack limit).
module tb_cpu_core_p;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int NREG   = 8;
    localparam int SP_W   = 2;

    logic              clock, reset, run;
    logic [ADDR_W-1:0] imem_addr, dmem_addr, o_pc;
    logic [15:0]       imem_rdata;
    logic              dmem_we, smem_we, halted, fault;
    logic [DATA_W-1:0] dmem_wdata, dmem_rdata, smem_wdata, smem_rdata, o_r0;
    logic [SP_W-1:0]   smem_addr, o_sp;
    logic [2:0]        o_state, o_flags;

    logic [15:0]       imem [256];
    logic [DATA_W-1:0] dmem [256];
    logic [DATA_W-1:0] smem [4];

    int n_checks = 0;
    int n_pass   = 0;

    cpu_core_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG), .SP_W(SP_W)) dut (
        .clock(clock), .reset(reset), .run(run),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .smem_addr(smem_addr), .smem_we(smem_we), .smem_wdata(smem_wdata), .smem_rdata(smem_rdata),
        .halted(halted), .fault(fault), .o_pc(o_pc), .o_sp(o_sp), .o_r0(o_r0),
        .o_state(o_state), .o_flags(o_flags)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        imem_rdata <= imem[imem_addr[7:0]];
        dmem_rdata <= dmem[dmem_addr[7:0]];
        smem_rdata <= smem[smem_addr];
        if (dmem_we) dmem[dmem_addr[7:0]] <= dmem_wdata;
        if (smem_we) smem[smem_addr] <= smem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run   = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = 16'hF800;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        run   = 1'b0;

        // Run gating, then reset in the middle of a store.
        do_reset();
        imem[0] = 16'h0000;
        imem[1] = 16'h2210;
        check("rst_pc", 32'(o_pc), 'h0);
        check("rst_sp", 32'(o_sp), 'h0);
        check("rst_r0", 32'(o_r0), 'h0);
        check("rst_state", 32'(o_state), 'h0);
        check("rst_flags", 32'(o_flags), 'h1);
        check("rst_halted", 32'(halted), 'h0);
        check("rst_fault", 32'(fault), 'h0);
        check("rst_strobes", 32'({dmem_we, smem_we}), 'h0);
        step(10);
        check("hold_state", 32'(o_state), 'h0);
        check("hold_pc", 32'(o_pc), 'h0);
        run = 1'b1;
        step(1);
        check("decode_state", 32'(o_state), 'h1);
        step(1);
        check("exec_state", 32'(o_state), 'h2);
        step(1);
        check("nop_pc", 32'(o_pc), 'h1);
        step(2);
        check("st_exec_we", 32'(dmem_we), 'h1);
        reset = 1'b0;
        #1;
        check("abort_we", 32'(dmem_we), 'h0);
        check("abort_pc", 32'(o_pc), 'h0);
        check("abort_state", 32'(o_state), 'h0);

        // Accumulator and carry.
        do_reset();
        imem[0] = 16'h10FF;
        imem[1] = 16'h2808;
        imem[2] = 16'h30FF;
        imem[3] = 16'h3001;
        imem[4] = 16'h4020;
        run = 1'b1;
        step(3);
        check("li_r0", 32'(o_r0), 'h00FF);
        check("li_flags", 32'(o_flags), 'h0);
        step(3);
        check("shl_r0", 32'(o_r0), 'hFF00);
        check("shl_flags", 32'(o_flags), 'h2);
        step(3);
        check("add_r0", 32'(o_r0), 'hFFFF);
        check("add_flags", 32'(o_flags), 'h2);
        step(3);
        check("addc_r0", 32'(o_r0), 'h0000);
        check("addc_flags", 32'(o_flags), 'h5);
        check("addc_pc", 32'(o_pc), 'h4);
        step(3);
        check("jz_pc", 32'(o_pc), 'h20);
        check("jz_state", 32'(o_state), 'h0);

        // Load/store through R2 and R3.
        do_reset();
        imem[0] = 16'h1205;
        imem[1] = 16'h2210;
        imem[2] = 16'h0B10;
        imem[3] = 16'h1803;
        run = 1'b1;
        step(3);
        check("st_pre_we", 32'(dmem_we), 'h0);
        step(2);
        check("st_we", 32'(dmem_we), 'h1);
        check("st_addr", 32'(dmem_addr), 'h10);
        check("st_data", 32'(dmem_wdata), 'h5);
        step(1);
        check("st_we_drop", 32'(dmem_we), 'h0);
        check("st_mem", 32'(dmem[8'h10]), 'h5);
        step(3);
        check("ld_mem_state", 32'(o_state), 'h3);
        check("ld_pc", 32'(o_pc), 'h3);
        step(1);
        check("ld_done_state", 32'(o_state), 'h0);
        step(3);
        check("mov_r3_r0", 32'(o_r0), 'h5);

        // Call/return, then HALT.
        do_reset();
        for (int i = 0; i < 5; i++) imem[i] = 16'h0000;
        imem[5]    = 16'h9040;
        imem[6]    = 16'hF800;
        imem[8'h40] = 16'h9800;
        run = 1'b1;
        step(15);
        check("nops_pc", 32'(o_pc), 'h5);
        step(2);
        check("call_we", 32'(smem_we), 'h1);
        check("call_addr", 32'(smem_addr), 'h0);
        check("call_data", 32'(smem_wdata), 'h6);
        step(1);
        check("call_sp", 32'(o_sp), 'h1);
        check("call_pc", 32'(o_pc), 'h40);
        check("call_mem", 32'(smem[0]), 'h6);
        step(3);
        check("ret_mem_state", 32'(o_state), 'h3);
        check("ret_sp", 32'(o_sp), 'h0);
        step(1);
        check("ret_pc", 32'(o_pc), 'h6);
        step(3);
        check("halt_flag", 32'(halted), 'h1);
        check("halt_state", 32'(o_state), 'h4);
        step(10);
        check("halt_sticky", 32'(o_state), 'h4);
        check("halt_pc", 32'(o_pc), 'h7);
        check("halt_strobes", 32'({dmem_we, smem_we}), 'h0);

        // Stack limit with a 4-entry stack.
        do_reset();
        imem[0] = 16'h11AB;
        for (int i = 1; i < 5; i++) imem[i] = 16'h8100;
        run = 1'b1;
        step(12);
        check("push3_sp", 32'(o_sp), 'h3);
        check("push_mem0", 32'(smem[0]), 'hAB);
        check("push_mem2", 32'(smem[2]), 'hAB);
        step(2);
`ifdef CPU_STACK_GUARD_EN
        check("guard_we", 32'(smem_we), 'h0);
        step(1);
        check("guard_fault", 32'(fault), 'h1);
        check("guard_state", 32'(o_state), 'h5);
        check("guard_sp", 32'(o_sp), 'h3);
        check("guard_pc", 32'(o_pc), 'h4);
        step(5);
        check("guard_sticky", 32'(o_state), 'h5);
`else
        check("wrap_we", 32'(smem_we), 'h1);
        check("wrap_addr", 32'(smem_addr), 'h3);
        step(1);
        check("wrap_sp", 32'(o_sp), 'h0);
        check("wrap_pc", 32'(o_pc), 'h5);
        check("wrap_mem3", 32'(smem[3]), 'hAB);
        check("wrap_fault", 32'(fault), 'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_core_p.md
Name: cpu_core_p

Overview:
- Parametrised successor to the team's multi-cycle 16-bit accumulator CPU core; datapath width, register count and stack depth are set by parameters.
- Instruction, data and stack memories live outside the block, each behind a synchronous-read port with 1-cycle latency.
- Adds beyond the previous core: carry flag, JC and JN (MSB-based), PUSH, POP, CALL, RET, a sticky HALT, and a run-enable input.

Parameters:
- DATA_W, 16, register, ALU and data/stack memory word width (≥8).
- ADDR_W, 16, instruction and data memory address width (≥8).
- NREG, 8, number of registers R0..NREG-1 (4..8); R0 is the accumulator.
- SP_W, 8, stack memory address width.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  1 = allow fetch; sampled in FETCH only
- imem_addr  out  ADDR_W  instruction address, always equal to pc
- imem_rdata  in  16  instruction word, valid 1 cycle after address
- dmem_addr  out  ADDR_W  data address, zero-extended ir[7:0]
- dmem_we  out  1  data write strobe, 1 cycle
- dmem_wdata  out  DATA_W  data write value
- dmem_rdata  in  DATA_W  data read value, 1-cycle latency
- smem_addr  out  SP_W  stack address
- smem_we  out  1  stack write strobe
- smem_wdata  out  DATA_W  stack write value
- smem_rdata  in  DATA_W  stack read value, 1-cycle latency
- halted  out  1  HALT executed
- fault  out  1  stack guard tripped
- o_pc  out  ADDR_W  program counter
- o_sp  out  SP_W  stack pointer
- o_r0  out  DATA_W  accumulator
- o_state  out  3  FSM state: FETCH=0, DECODE=1, EXEC=2, MEM=3, HALT=4, FAULT=5
- o_flags  out  3  {C, N, Z}

Behaviour:
- Reset (asynchronous, active-low): pc, sp, all registers, C and ir cleared to 0; state FETCH; dmem_we=smem_we=0; halted=fault=0.
- Reset asserted mid-instruction aborts it; write strobes deassert immediately.
- Instruction encoding: op=ir[15:11], f=ir[10:8], imm=ir[7:0].
- Source operand S: f=0 selects zero-extended imm; f=1..7 selects R[f].
- Register index ≥ NREG: reads return 0, writes are ignored.
- FETCH: if run=1, go to DECODE; otherwise hold with pc unchanged.
- DECODE: ir <= imem_rdata; go to EXEC.
- EXEC: execute the instruction; next state is FETCH unless listed otherwise.
- LD (1) and POP (17): EXEC presents the address and goes to MEM; MEM writes the read data to R[f], then FETCH.
- Latency: 3 cycles per instruction; LD, POP and RET take 4.
- Opcode list:
  - 0 NOP
  - 1 LD: R[f] <= dmem[imm]
  - 2 LI: R[f] <= zero-extended imm
  - 3 MOV: R[f] <= R[ir[2:0]]
  - 4 ST: dmem[imm] <= R[f]; dmem_we high during EXEC only
  - 5 SHL: R0 <<= S[log2(DATA_W)-1:0]
  - 14 SHR: R0 >>= S[log2(DATA_W)-1:0], logical
  - 6 ADD: {C,R0} <= R0+S
  - 7 SUB: {C,R0} <= R0-S; C=1 on borrow
  - 11 XOR, 12 OR, 13 AND: R0 <= R0 op S
  - 15 NOT: R0 <= ~R0
  - 8 JZ (Z), 9 JN (N), 20 JC (C), 10 JMP (always): pc <= S if condition true, else pc+1
  - 16 PUSH: smem[sp] <= R[f]; sp++
  - 17 POP: sp--; R[f] <= smem[sp-1], the post-decrement slot
  - 18 CALL: smem[sp] <= pc+1; sp++; pc <= S
  - 19 RET: sp--; pc <= smem[sp-1] in MEM
  - 31 HALT: enter HALT
  - all other opcodes execute as NOP
- Operand widths: S and memory data are zero-extended or truncated to the destination width.
- pc and sp wrap modulo 2^ADDR_W and 2^SP_W.
- Flags: Z = (R0==0) and N = R0[DATA_W-1], both combinational. C is registered, changes only on ADD/SUB, and is cleared at reset.
- pc <= pc+1 at the end of every non-taken, non-CALL/RET instruction.
- HALT state is sticky until reset; halted=1; no memory strobes.

Optional Feature:
- Macro: CPU_STACK_GUARD_EN
- Defined: a PUSH or CALL with sp = all-ones, or a POP or RET with sp = 0, enters FAULT instead of executing:
  - fault=1, sticky until reset
  - no smem_we, and sp, pc and registers unchanged
  - usable stack depth is 2^SP_W-1
- Undefined: the same conditions wrap sp silently; fault is tied to 0 and FAULT is unreachable.

Test Plan:
- Accumulator and carry (DATA_W=16), program 0x10FF, 0x2808, 0x30FF, 0x3001, 0x4020 -> R0 steps 0x00FF, 0xFF00, 0xFFFF, 0x0000; C=1, Z=1; pc=0x20 after JZ; 15 cycles total.
- Load/store: 0x1205 (R2=0x0005), 0x2210 (ST R2 to [0x10]), 0x0B10 (LD R3 from [0x10]) -> dmem_we high exactly 1 cycle with addr 0x10, data 0x0005; R3=0x0005; LD takes 4 cycles.
- Call/return: CALL 0x40 (0x9040) at pc=0x05 -> smem write addr 0, data 0x0006, sp=1, pc=0x40. RET (0x9800) -> pc=0x0006, sp=0.
- Stack guard (SP_W=2, macro defined): three PUSH R1 -> sp=3. Fourth PUSH -> fault=1, o_state=5, no smem_we. Same bench with macro undefined -> fourth push writes smem[3], sp=0.
- Run/halt/reset: run=0 -> state holds FETCH with pc unchanged for 10 cycles. HALT (0xF800) -> halted=1, pc frozen. reset low during ST EXEC -> dmem_we drops immediately, pc=0.
